// File: rtl/sha2_pkg.sv
// rtl/sha2_pkg.sv - shared constants and helpers for the SHA-2 message schedule
package sha2_pkg;

   localparam int IDX_W = 7;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   // sigma0 / sigma1 rotate and shift amounts, SHA-224/256
   localparam int S256_S0_R1 = 7;
   localparam int S256_S0_R2 = 18;
   localparam int S256_S0_SH = 3;
   localparam int S256_S1_R1 = 17;
   localparam int S256_S1_R2 = 19;
   localparam int S256_S1_SH = 10;

   // sigma0 / sigma1 rotate and shift amounts, SHA-384/512
   localparam int S512_S0_R1 = 1;
   localparam int S512_S0_R2 = 8;
   localparam int S512_S0_SH = 7;
   localparam int S512_S1_R1 = 19;
   localparam int S512_S1_R2 = 61;
   localparam int S512_S1_SH = 6;

   function automatic int rounds(input int wordsize);
      return (wordsize == 64) ? 80 : 64;
   endfunction

endpackage

// File: rtl/sha2_msg_sigma.sv
// rtl/sha2_msg_sigma.sv - combinational small-sigma function, i_sel=0 gives sigma0, 1 gives sigma1
module sha2_msg_sigma
   import sha2_pkg::*;
#(
   parameter int WORDSIZE = 32
) (
   input  logic                i_sel,
   input  logic [WORDSIZE-1:0] i_x,
   output logic [WORDSIZE-1:0] o_y
);

   localparam bit W64 = (WORDSIZE == 64);
   localparam int S0_R1 = W64 ? S512_S0_R1 : S256_S0_R1;
   localparam int S0_R2 = W64 ? S512_S0_R2 : S256_S0_R2;
   localparam int S0_SH = W64 ? S512_S0_SH : S256_S0_SH;
   localparam int S1_R1 = W64 ? S512_S1_R1 : S256_S1_R1;
   localparam int S1_R2 = W64 ? S512_S1_R2 : S256_S1_R2;
   localparam int S1_SH = W64 ? S512_S1_SH : S256_S1_SH;

   function automatic logic [WORDSIZE-1:0] rotr(input logic [WORDSIZE-1:0] x, input int n);
      return (x >> n) | (x << (WORDSIZE - n));
   endfunction

   logic [WORDSIZE-1:0] w_s0;
   logic [WORDSIZE-1:0] w_s1;

   always_comb begin
      w_s0 = rotr(i_x, S0_R1) ^ rotr(i_x, S0_R2) ^ (i_x >> S0_SH);
      w_s1 = rotr(i_x, S1_R1) ^ rotr(i_x, S1_R2) ^ (i_x >> S1_SH);
      o_y  = i_sel ? w_s1 : w_s0;
   end

endmodule

// File: rtl/sha2_msg_schedule.sv
// rtl/sha2_msg_schedule.sv - SHA-2 message schedule: streams W[0..R-1] from a 16-word sliding window
module sha2_msg_schedule
   import sha2_pkg::*;
#(
   parameter int WORDSIZE = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_blk_valid,
   output logic                  o_blk_ready,
   input  logic [16*WORDSIZE-1:0] i_blk_data,
   output logic                  o_w_valid,
   input  logic                  i_w_ready,
   output logic [WORDSIZE-1:0]   o_w_data,
   output logic [IDX_W-1:0]      o_w_idx,
   output logic                  o_w_last
);

   if (!(WORDSIZE == 32 || WORDSIZE == 64)) begin : g_bad_wordsize
      $error("sha2_msg_schedule: WORDSIZE must be 32 or 64");
   end

   localparam int               R    = rounds(WORDSIZE);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(R - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    r_t;
   logic [WORDSIZE-1:0] r_win [16];

   logic                w_at_last;
   logic                w_load;
   logic                w_shift;
   logic                w_go_idle;
   logic [WORDSIZE-1:0] w_s0;
   logic [WORDSIZE-1:0] w_s1;
   logic [WORDSIZE-1:0] w_next;

   sha2_msg_sigma #(.WORDSIZE(WORDSIZE)) u_sigma0 (
      .i_sel (1'b0),
      .i_x   (r_win[1]),
      .o_y   (w_s0)
   );

   sha2_msg_sigma #(.WORDSIZE(WORDSIZE)) u_sigma1 (
      .i_sel (1'b1),
      .i_x   (r_win[14]),
      .o_y   (w_s1)
   );

   // W[t+16]; single-cycle adder tree, carries beyond WORDSIZE dropped
   assign w_next    = w_s1 + r_win[9] + w_s0 + r_win[0];
   assign w_at_last = (r_t == LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_go_idle   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_blk_valid) begin
               w_load      = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (i_w_ready) begin
               if (!w_at_last) begin
                  w_shift = 1'b1;
               end else if (i_blk_valid) begin
                  w_load = 1'b1;
               end else begin
                  w_go_idle   = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_t <= '0;
         for (int i = 0; i < 16; i++) r_win[i] <= '0;
      end else if (w_load) begin
         r_t <= '0;
         for (int i = 0; i < 16; i++) r_win[i] <= i_blk_data[(15-i)*WORDSIZE +: WORDSIZE];
      end else if (w_shift) begin
         r_t <= r_t + 1'b1;
         for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
         r_win[15] <= w_next;
      end else if (w_go_idle) begin
         r_t <= '0;
      end
   end

   assign o_w_valid   = (r_state == ST_RUN);
   assign o_w_data    = r_win[0];
   assign o_w_idx     = r_t;
   assign o_w_last    = o_w_valid && w_at_last;
   assign o_blk_ready = (r_state == ST_IDLE) || (o_w_valid && i_w_ready && w_at_last);

endmodule

// File: tb/tb_sha2_msg_schedule.sv
// tb/tb_sha2_msg_schedule.sv - scoreboard bench for sha2_msg_schedule, SHA-256 and SHA-512 instances
module tb_sha2_msg_schedule;

   typedef struct {
      logic [63:0] data;
      int          idx;
      bit          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   logic          blk_valid32 = 1'b0;
   logic          blk_ready32;
   logic [511:0]  blk_data32 = '0;
   logic          w_valid32;
   logic          w_ready32 = 1'b1;
   logic [31:0]   w_data32;
   logic [6:0]    w_idx32;
   logic          w_last32;

   logic          blk_valid64 = 1'b0;
   logic          blk_ready64;
   logic [1023:0] blk_data64 = '0;
   logic          w_valid64;
   logic          w_ready64 = 1'b1;
   logic [63:0]   w_data64;
   logic [6:0]    w_idx64;
   logic          w_last64;

   exp_t          q32[$];
   exp_t          q64[$];
   logic [63:0]   obs32 [128];
   int            n_vec = 0;
   int            n_err = 0;
   int            ready_mode = 0;
   int            run32 = 0;
   int            max_run32 = 0;

   logic [63:0]   blk_abc32 [16];
   logic [63:0]   blk_abc64 [16];
   logic [63:0]   blk_ones  [16];
   logic [63:0]   blk_rnd   [16];

   sha2_msg_schedule #(.WORDSIZE(32)) dut32 (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_blk_valid (blk_valid32),
      .o_blk_ready (blk_ready32),
      .i_blk_data  (blk_data32),
      .o_w_valid   (w_valid32),
      .i_w_ready   (w_ready32),
      .o_w_data    (w_data32),
      .o_w_idx     (w_idx32),
      .o_w_last    (w_last32)
   );

   sha2_msg_schedule #(.WORDSIZE(64)) dut64 (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_blk_valid (blk_valid64),
      .o_blk_ready (blk_ready64),
      .i_blk_data  (blk_data64),
      .o_w_valid   (w_valid64),
      .i_w_ready   (w_ready64),
      .o_w_data    (w_data64),
      .o_w_idx     (w_idx64),
      .o_w_last    (w_last64)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] rotr(input bit m64, input logic [63:0] x, input int n);
      logic [31:0] y;
      y = x[31:0];
      if (m64) return (x >> n) | (x << (64 - n));
      return {32'h0, (y >> n) | (y << (32 - n))};
   endfunction

   function automatic logic [63:0] sig0(input bit m64, input logic [63:0] x);
      if (m64) return rotr(1'b1, x, 1) ^ rotr(1'b1, x, 8) ^ (x >> 7);
      return rotr(1'b0, x, 7) ^ rotr(1'b0, x, 18) ^ {32'h0, x[31:0] >> 3};
   endfunction

   function automatic logic [63:0] sig1(input bit m64, input logic [63:0] x);
      if (m64) return rotr(1'b1, x, 19) ^ rotr(1'b1, x, 61) ^ (x >> 6);
      return rotr(1'b0, x, 17) ^ rotr(1'b0, x, 19) ^ {32'h0, x[31:0] >> 10};
   endfunction

   task automatic push_exp(input bit m64, input logic [63:0] b [16]);
      logic [63:0] w [80];
      int          nr;
      exp_t        e;
      nr = m64 ? 80 : 64;
      for (int t = 0; t < 16; t++) w[t] = m64 ? b[t] : {32'h0, b[t][31:0]};
      for (int t = 16; t < nr; t++) begin
         w[t] = sig1(m64, w[t-2]) + w[t-7] + sig0(m64, w[t-15]) + w[t-16];
         if (!m64) w[t][63:32] = 32'h0;
      end
      for (int t = 0; t < nr; t++) begin
         e.data = w[t];
         e.idx  = t;
         e.last = (t == nr - 1);
         if (m64) q64.push_back(e);
         else     q32.push_back(e);
      end
   endtask

   task automatic offer(input bit m64, input logic [63:0] b [16]);
      bit got;
      push_exp(m64, b);
      for (int i = 0; i < 16; i++) begin
         if (m64) blk_data64[(15-i)*64 +: 64] = b[i];
         else     blk_data32[(15-i)*32 +: 32] = b[i][31:0];
      end
      if (m64) blk_valid64 = 1'b1;
      else     blk_valid32 = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 600 && !got; c++) begin
         @(negedge clk);
         got = m64 ? blk_ready64 : blk_ready32;
      end
      if (!got) check("handshake", 64'(got), 64'd1);
      @(posedge clk);
      #1;
      if (m64) blk_valid64 = 1'b0;
      else     blk_valid32 = 1'b0;
   endtask

   task automatic drain(input bit m64);
      int n;
      n = m64 ? q64.size() : q32.size();
      for (int c = 0; c < 2000 && n != 0; c++) begin
         @(posedge clk);
         n = m64 ? q64.size() : q32.size();
      end
      check(m64 ? "drain64" : "drain32", 64'(n), 64'd0);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      w_ready32 = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // 32-bit monitor: every valid cycle, stalled or not, must show the scoreboard head
   always @(negedge clk) begin
      if (!rst && w_valid32) begin
         run32++;
         if (run32 > max_run32) max_run32 = run32;
         if (q32.size() == 0) begin
            check("unexpected_w32", 64'd1, 64'd0);
         end else begin
            check("w_data32", 64'(w_data32), q32[0].data);
            check("w_idx32",  64'(w_idx32),  64'(q32[0].idx));
            check("w_last32", 64'(w_last32), 64'(q32[0].last));
            if (w_ready32) begin
               obs32[w_idx32] = 64'(w_data32);
               void'(q32.pop_front());
            end
         end
      end else begin
         run32 = 0;
      end
   end

   always @(negedge clk) begin
      if (!rst && w_valid64) begin
         if (q64.size() == 0) begin
            check("unexpected_w64", 64'd1, 64'd0);
         end else begin
            check("w_data64",    w_data64,          q64[0].data);
            check("w_idx64",     64'(w_idx64),      64'(q64[0].idx));
            check("w_last64",    64'(w_last64),     64'(q64[0].last));
            check("blk_ready64", 64'(blk_ready64),  64'(w_ready64 && q64[0].last));
            if (w_ready64) void'(q64.pop_front());
         end
      end
   end

   initial begin
      bit hit;
      for (int i = 0; i < 16; i++) begin
         blk_abc32[i] = '0;
         blk_abc64[i] = '0;
         blk_ones[i]  = 64'h0000_0000_FFFF_FFFF;
         blk_rnd[i]   = {32'h0, $urandom()};
      end
      blk_abc32[0]  = 64'h0000_0000_6162_6380;
      blk_abc32[15] = 64'h0000_0000_0000_0018;
      blk_abc64[0]  = 64'h6162_6380_0000_0000;
      blk_abc64[15] = 64'h0000_0000_0000_0018;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_w_valid32",   64'(w_valid32),   64'd0);
      check("rst_blk_ready32", 64'(blk_ready32), 64'd1);
      check("rst_w_data32",    64'(w_data32),    64'd0);
      check("rst_w_idx32",     64'(w_idx32),     64'd0);
      check("rst_w_last32",    64'(w_last32),    64'd0);
      check("rst_w_valid64",   64'(w_valid64),   64'd0);
      check("rst_blk_ready64", 64'(blk_ready64), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      offer(1'b0, blk_abc32);
      drain(1'b0);
      check("abc_w16", obs32[16], 64'h0000_0000_6162_6380);
      check("abc_w17", obs32[17], 64'h0000_0000_000F_0000);

      offer(1'b1, blk_abc64);
      drain(1'b1);

      ready_mode = 1;
      offer(1'b0, blk_abc32);
      drain(1'b0);
      ready_mode = 0;
      #20;

      max_run32 = 0;
      offer(1'b0, blk_rnd);
      offer(1'b0, blk_abc32);
      drain(1'b0);
      check("b2b_run_len", 64'(max_run32), 64'd128);

      offer(1'b0, blk_ones);
      drain(1'b0);

      offer(1'b0, blk_rnd);
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
         @(negedge clk);
         hit = w_valid32 && (w_idx32 == 7'd20);
      end
      check("reach_t20", 64'(hit), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      q32.delete();
      @(negedge clk);
      check("midrst_w_valid",   64'(w_valid32),   64'd0);
      check("midrst_blk_ready", 64'(blk_ready32), 64'd1);
      check("midrst_w_idx",     64'(w_idx32),     64'd0);
      check("midrst_w_data",    64'(w_data32),    64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      offer(1'b0, blk_abc32);
      drain(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
